// File: rtl/jtframe_sdram_mux_pkg.sv
// Shared types and the round-robin helper for the SDRAM read multiplexer.
package jtframe_sdram_mux_pkg;

    localparam int BW = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_RDY
    } state_t;

    // First set bit of req_mask after 'last', wrapping at 'slots'; keeps 'last' if none.
    function automatic int unsigned rr_next(
        input logic [7:0]  req_mask,
        input int unsigned last,
        input int unsigned slots
    );
        int unsigned g;
        int unsigned idx;
        logic        found;
        g     = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = (last + i) % slots;
            if (!found && i <= slots && |(req_mask & (8'd1 << idx))) begin
                g     = idx;
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/jtframe_sdram_mux_slot.sv
// One-entry read cache for a single requester, with hit compare and ok flag.
module jtframe_sdram_mux_slot
    import jtframe_sdram_mux_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic [BW-1:0] bank,
    input  logic          fill,
    input  logic [AW-1:0] lat_addr,
    input  logic [BW-1:0] lat_bank,
    input  logic [DW-1:0] data_read,
    output logic          ok,
    output logic [DW-1:0] dout,
    output logic          miss
);

    logic [AW-1:0] caddr;
    logic [BW-1:0] cbank;
    logic [DW-1:0] cdata;
    logic          valid;
    logic          hit;
    logic          lat_match;

    assign hit       = req & valid & (addr == caddr) & (bank == cbank);
    assign lat_match = (addr == lat_addr) & (bank == lat_bank);
    assign miss      = req & ~hit;
    assign dout      = cdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            caddr <= '0;
            cbank <= '0;
            cdata <= '0;
            valid <= 1'b0;
            ok    <= 1'b0;
        end else begin
            if (downloading) begin
                valid <= 1'b0;
            end else if (fill) begin
                caddr <= lat_addr;
                cbank <= lat_bank;
                cdata <= data_read;
                valid <= 1'b1;
            end
            // A fill for an address the client has since left must not flag ok
            ok <= req & (hit | (fill & lat_match));
        end
    end

endmodule

// File: rtl/jtframe_sdram_mux.sv
// Round-robin SDRAM read arbiter in front of per-slot one-entry caches.
module jtframe_sdram_mux
    import jtframe_sdram_mux_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
) (
    input  logic                clk_rom,
    input  logic                rst,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    input  logic [SLOTS*2-1:0]  slot_bank,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    output logic [1:0]          sdram_bank,
    input  logic                sdram_ack,
    input  logic [DW-1:0]       data_read,
    input  logic                data_rdy,
    output logic                busy
);

    localparam int GW = $clog2(SLOTS);

    state_t         state;
    logic [GW-1:0]  grant;
    logic [GW-1:0]  last;
    logic [GW-1:0]  next_g;
    logic [AW-1:0]  lat_addr;
    logic [BW-1:0]  lat_bank;
    logic           drop;
    logic           done;
    logic [SLOTS-1:0] miss;
    logic [SLOTS-1:0] fill;
    logic [7:0]     mask8;
    logic [AW-1:0]  addr_a [SLOTS];
    logic [BW-1:0]  bank_a [SLOTS];

    always_comb begin
        mask8 = '0;
        mask8[SLOTS-1:0] = miss;
    end

    assign next_g = GW'(rr_next(mask8, 32'(last), SLOTS));

    assign done = (state == WAIT_ACK && sdram_ack && data_rdy) ||
                  (state == WAIT_RDY && data_rdy);

    // Fills seen during or after a download are stale and must not land
    always_comb begin
        fill = '0;
        if (done && !drop && !downloading) fill[grant] = 1'b1;
    end

    always_ff @(posedge clk_rom) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            sdram_bank <= '0;
            lat_addr   <= '0;
            lat_bank   <= '0;
            grant      <= '0;
            last       <= GW'(SLOTS - 1);
            drop       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!downloading && |miss) begin
                        grant      <= next_g;
                        sdram_addr <= addr_a[next_g];
                        sdram_bank <= bank_a[next_g];
                        lat_addr   <= addr_a[next_g];
                        lat_bank   <= bank_a[next_g];
                        sdram_req  <= 1'b1;
                        drop       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (downloading) drop <= 1'b1;
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (data_rdy) begin
                            last  <= grant;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (downloading) drop <= 1'b1;
                    if (data_rdy) begin
                        last  <= grant;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    sdram_req <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign addr_a[i] = slot_addr[i*AW +: AW];
        assign bank_a[i] = slot_bank[i*2 +: 2];

        jtframe_sdram_mux_slot #(
            .AW (AW),
            .DW (DW)
        ) u_slot (
            .clk         (clk_rom),
            .rst         (rst),
            .downloading (downloading),
            .req         (slot_req[i]),
            .addr        (addr_a[i]),
            .bank        (bank_a[i]),
            .fill        (fill[i]),
            .lat_addr    (lat_addr),
            .lat_bank    (lat_bank),
            .data_read   (data_read),
            .ok          (slot_ok[i]),
            .dout        (slot_dout[i*DW +: DW]),
            .miss        (miss[i])
        );
    end

endmodule

// File: tb/tb_jtframe_sdram_mux.sv
// Directed bench for the SDRAM read multiplexer.
module tb_jtframe_sdram_mux;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                downloading = 1'b0;
    logic [SLOTS-1:0]    slot_req = '0;
    logic [SLOTS*AW-1:0] slot_addr = '0;
    logic [SLOTS*2-1:0]  slot_bank = '0;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic [1:0]          sdram_bank;
    logic                sdram_ack = 1'b0;
    logic [DW-1:0]       data_read = '0;
    logic                data_rdy = 1'b0;
    logic                busy;

    int checks = 0;
    int errors = 0;

    jtframe_sdram_mux #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .clk_rom     (clk),
        .rst         (rst),
        .downloading (downloading),
        .slot_req    (slot_req),
        .slot_addr   (slot_addr),
        .slot_bank   (slot_bank),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_bank  (sdram_bank),
        .sdram_ack   (sdram_ack),
        .data_read   (data_read),
        .data_rdy    (data_rdy),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        slot_req = '0;
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        downloading = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Controller model: waits for a request, acks it, returns data next cycle
    task automatic do_txn(output logic [AW-1:0] a, output logic [1:0] b,
                          output logic seen);
        seen = 1'b0;
        a = '0;
        b = '0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (sdram_req) seen = 1'b1;
            else tick();
        end
        if (seen) begin
            a = sdram_addr;
            b = sdram_bank;
            tick();
            sdram_ack = 1'b1;
            tick();
            sdram_ack = 1'b0;
            data_read = {16'hCAFE, a[15:0]};
            data_rdy = 1'b1;
            tick();
            data_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (sdram_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b busy=%b want 0 0", sdram_req, busy);
        end
        checks++;
        if (slot_ok !== 4'h0 || slot_dout !== '0) begin
            errors++;
            $display("FAIL reset_slots: ok=%h dout=%h want 0 0", slot_ok, slot_dout);
        end
        checks++;
        if (sdram_addr !== '0 || sdram_bank !== 2'd0) begin
            errors++;
            $display("FAIL reset_addr: addr=%h bank=%h want 0 0", sdram_addr, sdram_bank);
        end
    endtask

    task automatic test_miss();
        slot_addr[0*AW +: AW] = 22'h000100;
        slot_bank[1:0] = 2'd1;
        slot_req[0] = 1'b1;
        tick();
        checks++;
        if (sdram_req !== 1'b1 || busy !== 1'b1 || sdram_addr !== 22'h000100 ||
            sdram_bank !== 2'd1) begin
            errors++;
            $display("FAIL miss_req: req=%b busy=%b addr=%h bank=%h want 1 1 000100 1",
                     sdram_req, busy, sdram_addr, sdram_bank);
        end
        tick();
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        checks++;
        if (sdram_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL miss_ack: req=%b busy=%b want 0 1", sdram_req, busy);
        end
        tick();
        tick();
        checks++;
        if (slot_ok[0] !== 1'b0) begin
            errors++;
            $display("FAIL miss_early_ok: ok=%b want 0", slot_ok[0]);
        end
        data_read = 32'hDEADBEEF;
        data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_ok[0] !== 1'b1 || slot_dout[31:0] !== 32'hDEADBEEF || busy !== 1'b0) begin
            errors++;
            $display("FAIL miss_fill: ok=%b dout=%h busy=%b want 1 deadbeef 0",
                     slot_ok[0], slot_dout[31:0], busy);
        end
    endtask

    task automatic test_hit();
        slot_req[0] = 1'b0;
        tick();
        checks++;
        if (slot_ok[0] !== 1'b0) begin
            errors++;
            $display("FAIL hit_drop: ok=%b want 0", slot_ok[0]);
        end
        slot_req[0] = 1'b1;
        tick();
        checks++;
        if (slot_ok[0] !== 1'b1 || sdram_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_again: ok=%b req=%b busy=%b want 1 0 0",
                     slot_ok[0], sdram_req, busy);
        end
        slot_req[0] = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] a;
        logic [1:0]    b;
        logic          seen;
        logic [AW-1:0] exp_a [5];
        exp_a[0] = 22'h200;
        exp_a[1] = 22'h201;
        exp_a[2] = 22'h202;
        exp_a[3] = 22'h203;
        exp_a[4] = 22'h300;
        apply_reset();
        for (int i = 0; i < SLOTS; i++) begin
            slot_addr[i*AW +: AW] = 22'h200 + 22'(i);
            slot_bank[i*2 +: 2] = 2'(i);
        end
        slot_req = 4'hF;
        tick();
        for (int k = 0; k < 5; k++) begin
            do_txn(a, b, seen);
            checks++;
            if (!seen || a !== exp_a[k]) begin
                errors++;
                $display("FAIL rr_order%0d: seen=%b addr=%h want 1 %h",
                         k, seen, a, exp_a[k]);
            end
            if (k == 0) slot_addr[0*AW +: AW] = 22'h300;
        end
        checks++;
        if (slot_ok !== 4'hF || busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_all_ok: ok=%h busy=%b want f 0", slot_ok, busy);
        end
        tick();
        checks++;
        if (sdram_req !== 1'b0 || slot_ok !== 4'hF) begin
            errors++;
            $display("FAIL rr_multi_hit: req=%b ok=%h want 0 f", sdram_req, slot_ok);
        end
        checks++;
        if (slot_dout[0 +: 32] !== 32'hCAFE0300 || slot_dout[96 +: 32] !== 32'hCAFE0203) begin
            errors++;
            $display("FAIL rr_data: d0=%h d3=%h want cafe0300 cafe0203",
                     slot_dout[0 +: 32], slot_dout[96 +: 32]);
        end
        slot_req = '0;
    endtask

    task automatic test_addr_change();
        logic [AW-1:0] a;
        logic [1:0]    b;
        logic          seen;
        apply_reset();
        slot_addr[2*AW +: AW] = 22'h10;
        slot_bank[5:4] = 2'd0;
        slot_req[2] = 1'b1;
        tick();
        checks++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h10) begin
            errors++;
            $display("FAIL chg_req: req=%b addr=%h want 1 10", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        slot_addr[2*AW +: AW] = 22'h20;
        tick();
        data_read = 32'h11111111;
        data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (slot_ok[2] !== 1'b0 || slot_dout[64 +: 32] !== 32'h11111111) begin
            errors++;
            $display("FAIL chg_fill: ok=%b dout=%h want 0 11111111",
                     slot_ok[2], slot_dout[64 +: 32]);
        end
        tick();
        checks++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h20) begin
            errors++;
            $display("FAIL chg_remiss: req=%b addr=%h want 1 20", sdram_req, sdram_addr);
        end
        do_txn(a, b, seen);
        checks++;
        if (!seen || slot_ok[2] !== 1'b1 || slot_dout[64 +: 32] !== 32'hCAFE0020) begin
            errors++;
            $display("FAIL chg_second: seen=%b ok=%b dout=%h want 1 1 cafe0020",
                     seen, slot_ok[2], slot_dout[64 +: 32]);
        end
    endtask

    task automatic test_downloading();
        logic any_req;
        logic [AW-1:0] a;
        logic [1:0]    b;
        logic          seen;
        slot_addr[2*AW +: AW] = 22'h30;
        tick();
        checks++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h30) begin
            errors++;
            $display("FAIL dl_req: req=%b addr=%h want 1 30", sdram_req, sdram_addr);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        downloading = 1'b1;
        tick();
        data_read = 32'h33333333;
        data_rdy = 1'b1;
        tick();
        data_rdy = 1'b0;
        checks++;
        if (busy !== 1'b0 || slot_ok[2] !== 1'b0) begin
            errors++;
            $display("FAIL dl_done: busy=%b ok=%b want 0 0", busy, slot_ok[2]);
        end
        any_req = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            any_req |= sdram_req | busy;
        end
        checks++;
        if (any_req !== 1'b0 || slot_ok[2] !== 1'b0) begin
            errors++;
            $display("FAIL dl_block: granted=%b ok=%b want 0 0", any_req, slot_ok[2]);
        end
        downloading = 1'b0;
        tick();
        checks++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h30) begin
            errors++;
            $display("FAIL dl_reread: req=%b addr=%h want 1 30", sdram_req, sdram_addr);
        end
        do_txn(a, b, seen);
        checks++;
        if (!seen || slot_ok[2] !== 1'b1 || slot_dout[64 +: 32] !== 32'hCAFE0030) begin
            errors++;
            $display("FAIL dl_fill: seen=%b ok=%b dout=%h want 1 1 cafe0030",
                     seen, slot_ok[2], slot_dout[64 +: 32]);
        end
        slot_req = '0;
    endtask

    task automatic test_reset_mid();
        slot_addr[1*AW +: AW] = 22'h50;
        slot_req = 4'b0110;
        slot_addr[2*AW +: AW] = 22'h30;
        tick();
        checks++;
        if (sdram_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: req=%b busy=%b want 1 1", sdram_req, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (sdram_req !== 1'b0 || busy !== 1'b0 || slot_ok !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_post: req=%b busy=%b ok=%h want 0 0 0",
                     sdram_req, busy, slot_ok);
        end
        slot_req = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_round_robin();
        test_addr_change();
        test_downloading();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
